// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates the raster position and timing strobes for a VGA display.
//   A horizontal pixel counter and a vertical line counter walk the full
//   frame, including the porch and sync regions. Every output comes straight
//   from a flop. blank, hs, vs and frame_start are computed from the counters'
//   next-state values, so each one lines up on the same cycle as the
//   DrawX/DrawY value it describes.
//
// Ports:
//   vga_clk      in   1   pixel clock, the only clock
//   reset_n      in   1   asynchronous active-low reset
//   DrawX        out  10  current pixel column (registered horizontal counter)
//   DrawY        out  10  current pixel row (registered vertical counter)
//   blank        out  1   1 = visible area (display enable), 0 = porch/sync
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   frame_start  out  1   one-cycle pulse while DrawX=0 and DrawY=0
//   frame_count  out  16  frames started since reset, wraps modulo 2^16
//
// Configuration macro:
//   VGA_SYNC_DELAY_EN - when defined, hs and vs pass through one extra
//   register stage (reset value 1). They then lag DrawX/DrawY/blank by one
//   cycle, which matches a renderer that registers its RGB output. The other
//   outputs are the same with or without the macro.
//
// Reset state: DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1. The first edge after
// reset is released therefore wraps both counters to (0,0) and starts
// frame 1.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Region boundaries, sized to the 10-bit counters.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Registered state
    logic [9:0]  h_q;
    logic [9:0]  v_q;
    logic        blank_q;
    logic        hs_q;
    logic        vs_q;
    logic        frame_start_q;
    logic [15:0] frame_count_q;

    // Next-state values
    logic        h_wrap;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic        blank_next;
    logic        hs_next;
    logic        vs_next;
    logic        frame_start_next;
    logic [15:0] frame_count_next;

    // Counter advance. The vertical counter only moves on a horizontal wrap.
    // Because of that, (H_LAST, V_LAST) goes to (0,0) on a single edge.
    always_comb begin
        h_wrap = 1'b0;
        h_next = h_q;
        v_next = v_q;

        h_wrap = (h_q == H_LAST);
        if (h_wrap) begin
            h_next = '0;
            if (v_q == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = v_q + 10'd1;
            end
        end else begin
            h_next = h_q + 10'd1;
        end
    end

    // Strobes are decoded from the next-state counters. Once registered, each
    // strobe sits on the same cycle as the position it describes.
    always_comb begin
        blank_next       = 1'b0;
        hs_next          = 1'b1;
        vs_next          = 1'b1;
        frame_start_next = 1'b0;
        frame_count_next = frame_count_q;

        blank_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
        hs_next    = !((h_next >= H_SYNC_START) && (h_next < H_SYNC_END));
        vs_next    = !((v_next >= V_SYNC_START) && (v_next < V_SYNC_END));

        frame_start_next = (h_next == '0) && (v_next == '0);
        // The count moves on the same edge that raises frame_start. It wraps
        // naturally from 16'hFFFF to 0.
        if (frame_start_next) begin
            frame_count_next = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_q           <= h_next;
            v_q           <= v_next;
            blank_q       <= blank_next;
            hs_q          <= hs_next;
            vs_q          <= vs_next;
            frame_start_q <= frame_start_next;
            frame_count_q <= frame_count_next;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stage: the syncs trail the pixel position by one cycle.
    logic hs_dly_q;
    logic vs_dly_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            hs_dly_q <= hs_q;
            vs_dly_q <= vs_q;
        end
    end

    assign hs = hs_dly_q;
    assign vs = vs_dly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16: horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96: hsync pulse width in pixels.
REQ-004 The module SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-005 The module SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 The module SHALL have parameter V_FRONT, default 10: vertical front porch in lines.
REQ-007 The module SHALL have parameter V_SYNC, default 2: vsync pulse width in lines.
REQ-008 The module SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-009 The module SHALL have port vga_clk, input, 1 bit: pixel clock, the single clock.
REQ-010 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 The module SHALL have port DrawX, output, 10 bits: current pixel column.
REQ-012 The module SHALL have port DrawY, output, 10 bits: current pixel row.
REQ-013 The module SHALL have port blank, output, 1 bit: 1 = visible (display enable), 0 = porch/sync; it feeds the downstream sprite renderer.
REQ-014 The module SHALL have port hs, output, 1 bit: horizontal sync, active low.
REQ-015 The module SHALL have port vs, output, 1 bit: vertical sync, active low.
REQ-016 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first pixel of each frame.
REQ-017 The module SHALL have port frame_count, output, 16 bits: number of frames started since reset.

Function
REQ-018 The horizontal counter SHALL increment every vga_clk rising edge and wrap from H_TOTAL-1 to 0.
REQ-019 The vertical counter SHALL increment only on horizontal wrap and wrap from V_TOTAL-1 to 0 when a horizontal wrap occurs at line V_TOTAL-1.
REQ-020 DrawX and DrawY SHALL equal the registered horizontal and vertical counters.
REQ-021 blank, hs, vs and frame_start SHALL be registered outputs computed from next-state counter values, so that each one is cycle-aligned with the DrawX/DrawY value it describes.
REQ-022 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-023 hs SHALL be 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC; with defaults this is 656..751 inclusive.
REQ-024 vs SHALL be 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC; with defaults this is 490..491 inclusive, held for whole lines.
REQ-025 frame_start SHALL be 1 exactly for the cycle in which DrawX=0 and DrawY=0.
REQ-026 frame_count SHALL increment by 1 in the same cycle that frame_start is asserted, wrapping modulo 2^16 from 16'hFFFF to 0 with no saturation.
REQ-027 The horizontal and vertical wrap SHALL occur in the same edge: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0).
REQ-028 No output SHALL glitch; all outputs SHALL come directly from flops.

Reset
REQ-029 While reset_n=0 the outputs SHALL be: DrawX=H_TOTAL-1, DrawY=V_TOTAL-1, blank=0, hs=1, vs=1, frame_start=0, frame_count=0.
REQ-030 Reset assertion SHALL take effect asynchronously, including mid-line and mid-sync pulse, with no partial frame completed.
REQ-031 The first rising edge after reset_n deasserts SHALL produce DrawX=0, DrawY=0, blank=1, frame_start=1 and frame_count=1.

Configuration
REQ-032 When macro VGA_SYNC_DELAY_EN is defined, hs and vs SHALL pass through one extra register stage, lagging DrawX/DrawY/blank by exactly 1 cycle to match the renderer's registered RGB output; their reset value SHALL be 1.
REQ-033 When VGA_SYNC_DELAY_EN is undefined, hs and vs SHALL be aligned per REQ-021 with no extra stage.
REQ-034 blank, DrawX, DrawY, frame_start and frame_count SHALL be unaffected by VGA_SYNC_DELAY_EN.

Verification
REQ-035 Release reset -> first edge gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1.
REQ-036 Run one line -> blank falls at DrawX=640; hs is low for exactly 96 cycles over DrawX=656..751; DrawX wraps 799->0 and DrawY increments.
REQ-037 Run one full frame -> exactly 420000 cycles between frame_start pulses; vs is low for 1600 cycles over DrawY=490..491; blank=0 for every DrawY>=480.
REQ-038 With VGA_SYNC_DELAY_EN defined -> hs falls one cycle after DrawX=656 is presented; vs timing shifts by 1 cycle; blank timing is unchanged.
REQ-039 Assert reset_n=0 at DrawX=700, DrawY=491 (hs=0, vs=0) -> hs=1, vs=1, DrawX=799, DrawY=524 immediately, without waiting for a clock edge; release then restarts at (0,0).
REQ-040 Force frame_count to 16'hFFFF then complete a frame -> frame_count=0 while frame_start=1.
